// File: rtl/i2c_slave_responder.sv
// I2C slave with a small byte memory behind a one-byte pointer; answers a single
// 7-bit address, stores written bytes (with a local strobe) and streams reads.
module i2c_slave_responder #(
    parameter logic [6:0]  SLAVE_ADDR     = 7'h22,
    parameter int unsigned MEM_ADDR_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic                      busy_o,
    output logic                      wr_valid_o,
    output logic [MEM_ADDR_WIDTH-1:0] wr_addr_o,
    output logic [7:0]                wr_data_o
);

    localparam int unsigned MemDepth = 1 << MEM_ADDR_WIDTH;

    localparam logic [3:0] StIdle     = 4'd0;
    localparam logic [3:0] StAddr     = 4'd1;
    localparam logic [3:0] StAddrAck  = 4'd2;
    localparam logic [3:0] StWrPtr    = 4'd3;
    localparam logic [3:0] StWrData   = 4'd4;
    localparam logic [3:0] StWrAck    = 4'd5;
    localparam logic [3:0] StRdByte   = 4'd6;
    localparam logic [3:0] StRdAck    = 4'd7;
    localparam logic [3:0] StWaitStop = 4'd8;

    logic scl_meta_q, scl_sync_q, scl_hist_q;
    logic sda_meta_q, sda_sync_q, sda_hist_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [3:0]                state_q, state_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [7:0]                shift_q, shift_d;
    logic                      ack_seen_q, ack_seen_d;
    logic                      rw_q, rw_d;
    logic [MEM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                      sda_q, sda_d;
    logic                      busy_q, busy_d;
    logic                      wr_valid_q, wr_valid_d;
    logic [MEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]                wr_data_q, wr_data_d;
    logic                      mem_we;
    logic [7:0]                rx_byte, rd_byte;
    logic [7:0]                mem_q [MemDepth];

    assign scl_rise  = scl_sync_q & ~scl_hist_q;
    assign scl_fall  = ~scl_sync_q & scl_hist_q;
    assign start_det = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
    assign rx_byte   = {shift_q[6:0], sda_sync_q};
    assign rd_byte   = mem_q[ptr_q];

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ack_seen_d = ack_seen_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        sda_d      = sda_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_we     = 1'b0;
        // Bus conditions win over any edge decoded in the same cycle.
        if (start_det) begin
            state_d    = StAddr;
            bit_cnt_d  = 3'd0;
            ack_seen_d = 1'b0;
            sda_d      = 1'b1;
        end else if (stop_det) begin
            state_d = StIdle;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_seen_d = 1'b0;
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_d = StAddrAck;
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                            end else begin
                                state_d = StWaitStop;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                StAddrAck: begin
                    // First fall drives the ACK, the fall after the 9th rise ends it.
                    if (scl_rise) begin
                        ack_seen_d = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (!ack_seen_q) begin
                            sda_d = 1'b0;
                        end else if (rw_q) begin
                            sda_d   = rd_byte[7];
                            shift_d = rd_byte;
                            state_d = StRdByte;
                        end else begin
                            sda_d   = 1'b1;
                            state_d = StWrPtr;
                        end
                    end
                end
                StWrPtr, StWrData: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_seen_d = 1'b0;
                            state_d    = StWrAck;
                            if (state_q == StWrPtr) begin
                                ptr_d = rx_byte[MEM_ADDR_WIDTH-1:0];
                            end else begin
                                mem_we     = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = rx_byte;
                                ptr_d      = ptr_q + 1'b1;
                            end
                        end
                    end
                end
                StWrAck: begin
                    if (scl_rise) begin
                        ack_seen_d = 1'b1;
                    end else if (scl_fall) begin
                        if (!ack_seen_q) begin
                            sda_d = 1'b0;
                        end else begin
                            sda_d     = 1'b1;
                            bit_cnt_d = 3'd0;
                            state_d   = StWrData;
                        end
                    end
                end
                StRdByte: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_d      = 1'b1;
                            ptr_d      = ptr_q + 1'b1;
                            ack_seen_d = 1'b0;
                            state_d    = StRdAck;
                        end else begin
                            sda_d     = shift_q[6];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        if (sda_sync_q) begin
                            state_d = StWaitStop;
                            busy_d  = 1'b0;
                        end else begin
                            ack_seen_d = 1'b1;
                        end
                    end else if (scl_fall && ack_seen_q) begin
                        sda_d     = rd_byte[7];
                        shift_d   = rd_byte;
                        bit_cnt_d = 3'd0;
                        state_d   = StRdByte;
                    end
                end
                StWaitStop: sda_d = 1'b1;
                StIdle:     sda_d = 1'b1;
                default:    state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            ack_seen_q <= 1'b0;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_hist_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_hist_q <= sda_sync_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ack_seen_q <= ack_seen_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            sda_q      <= sda_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MemDepth; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we) begin
            mem_q[ptr_q] <= rx_byte;
        end
    end

    assign scl_o      = 1'b1;
    assign sda_o      = sda_q;
    assign busy_o     = busy_q;
    assign wr_valid_o = wr_valid_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master on a wired-AND bus, directed
// sequences, a vector table and randomized transactions against a memory model.
module tb_i2c_slave_responder;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          m_scl, m_sda;
    logic          scl_o, sda_o, busy_o, wr_valid_o;
    logic [AW-1:0] wr_addr_o;
    logic [7:0]    wr_data_o;
    logic          bus_scl, bus_sda;

    assign bus_scl = m_scl & scl_o;
    assign bus_sda = m_sda & sda_o;

    i2c_slave_responder #(
        .SLAVE_ADDR     (7'h22),
        .MEM_ADDR_WIDTH (AW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (bus_scl),
        .sda_i      (bus_sda),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .busy_o     (busy_o),
        .wr_valid_o (wr_valid_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o)
    );

    typedef struct {
        logic [7:0]    ptr_byte;
        logic [7:0]    d0;
        logic [7:0]    d1;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
    } vec_t;

    vec_t          vecs [3];
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_strobes = 0;
    int            sda_low_cnt = 0;
    int            busy_cnt = 0;
    logic [AW-1:0] st_addr [256];
    logic [7:0]    st_data [256];
    logic [7:0]    tx_buf [32];
    logic [7:0]    rx_buf [32];
    logic [7:0]    model_mem [DEPTH];

    always @(negedge clk) begin
        if (wr_valid_o) begin
            if (n_strobes < 256) begin
                st_addr[n_strobes] <= wr_addr_o;
                st_data[n_strobes] <= wr_data_o;
            end
            n_strobes <= n_strobes + 1;
        end
        if (!sda_o) sda_low_cnt <= sda_low_cnt + 1;
        if (busy_o) busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_xfer(input logic b, output logic rx);
        m_sda = b;
        wait_clk(4);
        m_scl = 1'b1;
        wait_clk(4);
        rx = bus_sda;
        wait_clk(4);
        m_scl = 1'b0;
        wait_clk(4);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        wait_clk(4);
        m_scl = 1'b1;
        wait_clk(4);
        m_sda = 1'b0;
        wait_clk(4);
        m_scl = 1'b0;
        wait_clk(4);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        wait_clk(4);
        m_scl = 1'b1;
        wait_clk(4);
        m_sda = 1'b1;
        wait_clk(8);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack_bit, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            b[i] = r;
        end
        bit_xfer(ack_bit, r);
    endtask

    task automatic write_txn(input logic [7:0] pb, input int n);
        logic a;
        i2c_start();
        send_byte(8'h44, a);
        check("write addr ack", 32'(a), 32'd0);
        send_byte(pb, a);
        check("pointer ack", 32'(a), 32'd0);
        for (int i = 0; i < n; i++) begin
            send_byte(tx_buf[i], a);
            check("data ack", 32'(a), 32'd0);
        end
        i2c_stop();
    endtask

    task automatic read_txn(input bit set_ptr, input logic [7:0] pb, input int n,
                            input bit do_stop);
        logic       a;
        logic [7:0] b;
        i2c_start();
        if (set_ptr) begin
            send_byte(8'h44, a);
            check("read setup addr ack", 32'(a), 32'd0);
            send_byte(pb, a);
            check("read setup ptr ack", 32'(a), 32'd0);
            i2c_start();
        end
        send_byte(8'h45, a);
        check("read addr ack", 32'(a), 32'd0);
        for (int i = 0; i < n; i++) begin
            recv_byte((i == n - 1), b);
            rx_buf[i] = b;
        end
        if (do_stop) i2c_stop();
    endtask

    initial begin
        logic       a;
        logic [7:0] pb;
        int         base, s0, b0, mp, op, n;

        vecs[0] = '{8'h0F, 8'h11, 8'h22, 4'hF, 4'h0};
        vecs[1] = '{8'hF3, 8'h5A, 8'h6B, 4'h3, 4'h4};
        vecs[2] = '{8'h08, 8'h80, 8'h01, 4'h8, 4'h9};

        m_scl = 1'b1;
        m_sda = 1'b1;
        rst   = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        check("reset sda_o", 32'(sda_o), 32'd1);
        check("reset scl_o", 32'(scl_o), 32'd1);
        check("reset busy_o", 32'(busy_o), 32'd0);
        check("reset wr_valid_o", 32'(wr_valid_o), 32'd0);
        check("reset wr_addr_o", 32'(wr_addr_o), 32'd0);
        check("reset wr_data_o", 32'(wr_data_o), 32'd0);

        // Write 05 <- A5, 3C
        tx_buf[0] = 8'hA5;
        tx_buf[1] = 8'h3C;
        base = n_strobes;
        i2c_start();
        send_byte(8'h44, a);
        check("t1 addr ack", 32'(a), 32'd0);
        check("t1 busy after addr", 32'(busy_o), 32'd1);
        send_byte(8'h05, a);
        check("t1 ptr ack", 32'(a), 32'd0);
        send_byte(8'hA5, a);
        check("t1 data0 ack", 32'(a), 32'd0);
        send_byte(8'h3C, a);
        check("t1 data1 ack", 32'(a), 32'd0);
        i2c_stop();
        check("t1 busy after stop", 32'(busy_o), 32'd0);
        check("t1 strobe count", 32'(n_strobes - base), 32'd2);
        check("t1 strobe0 addr", 32'(st_addr[base]), 32'h5);
        check("t1 strobe0 data", 32'(st_data[base]), 32'hA5);
        check("t1 strobe1 addr", 32'(st_addr[base+1]), 32'h6);
        check("t1 strobe1 data", 32'(st_data[base+1]), 32'h3C);
        read_txn(1'b0, 8'h00, 1, 1'b1);
        check("t1 ptr is 7 (mem7)", 32'(rx_buf[0]), 32'h00);

        // Pointer 05, repeated START, read two bytes, NACK the second
        read_txn(1'b1, 8'h05, 2, 1'b0);
        check("t2 read byte0", 32'(rx_buf[0]), 32'hA5);
        check("t2 read byte1", 32'(rx_buf[1]), 32'h3C);
        check("t2 sda released after nack", 32'(sda_o), 32'd1);
        check("t2 busy after nack", 32'(busy_o), 32'd0);
        i2c_stop();

        // Pointer 06 then STOP after 4 data bits
        base = n_strobes;
        i2c_start();
        send_byte(8'h44, a);
        send_byte(8'h06, a);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, a);
        i2c_stop();
        check("t5 no strobe", 32'(n_strobes - base), 32'd0);
        check("t5 sda_o idle", 32'(sda_o), 32'd1);
        check("t5 busy idle", 32'(busy_o), 32'd0);
        read_txn(1'b0, 8'h00, 1, 1'b1);
        check("t5 mem6 unchanged", 32'(rx_buf[0]), 32'h3C);

        // Foreign address 0x23
        base = n_strobes;
        s0 = sda_low_cnt;
        b0 = busy_cnt;
        i2c_start();
        send_byte(8'h46, a);
        check("t3 nack on addr", 32'(a), 32'd1);
        send_byte(8'h99, a);
        check("t3 nack on data", 32'(a), 32'd1);
        i2c_stop();
        check("t3 no strobe", 32'(n_strobes - base), 32'd0);
        check("t3 sda never low", 32'(sda_low_cnt - s0), 32'd0);
        check("t3 busy never high", 32'(busy_cnt - b0), 32'd0);

        for (int v = 0; v < 3; v++) begin
            tx_buf[0] = vecs[v].d0;
            tx_buf[1] = vecs[v].d1;
            base = n_strobes;
            write_txn(vecs[v].ptr_byte, 2);
            check("vec strobe count", 32'(n_strobes - base), 32'd2);
            check("vec strobe0 addr", 32'(st_addr[base]), 32'(vecs[v].a0));
            check("vec strobe0 data", 32'(st_data[base]), 32'(vecs[v].d0));
            check("vec strobe1 addr", 32'(st_addr[base+1]), 32'(vecs[v].a1));
            check("vec strobe1 data", 32'(st_data[base+1]), 32'(vecs[v].d1));
            read_txn(1'b1, vecs[v].ptr_byte, 2, 1'b1);
            check("vec readback0", 32'(rx_buf[0]), 32'(vecs[v].d0));
            check("vec readback1", 32'(rx_buf[1]), 32'(vecs[v].d1));
        end

        // Reset while slave drives bit 7 (0) of mem[9]=01
        i2c_start();
        send_byte(8'h44, a);
        send_byte(8'h09, a);
        i2c_start();
        send_byte(8'h45, a);
        check("rst read ack", 32'(a), 32'd0);
        check("rst slave driving 0", 32'(sda_o), 32'd0);
        rst = 1'b1;
        wait_clk(1);
        check("rst sda released", 32'(sda_o), 32'd1);
        check("rst busy cleared", 32'(busy_o), 32'd0);
        rst = 1'b0;
        i2c_stop();
        read_txn(1'b0, 8'h00, 1, 1'b1);
        check("rst read mem0", 32'(rx_buf[0]), 32'h00);

        // Randomized phase: fill whole memory, then mixed transactions
        pb = 8'($urandom) & 8'hF0;
        for (int i = 0; i < DEPTH; i++) tx_buf[i] = 8'($urandom);
        base = n_strobes;
        write_txn(pb, DEPTH);
        mp = int'(pb) % DEPTH;
        check("rnd fill count", 32'(n_strobes - base), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            check("rnd fill addr", 32'(st_addr[base+i]), 32'(mp));
            check("rnd fill data", 32'(st_data[base+i]), 32'(tx_buf[i]));
            model_mem[mp] = tx_buf[i];
            mp = (mp + 1) % DEPTH;
        end
        for (int it = 0; it < 10; it++) begin
            op = int'($urandom_range(0, 2));
            n  = int'($urandom_range(1, 3));
            pb = 8'($urandom);
            if (op == 0) begin
                for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
                base = n_strobes;
                write_txn(pb, n);
                mp = int'(pb) % DEPTH;
                check("rnd wr count", 32'(n_strobes - base), 32'(n));
                for (int i = 0; i < n; i++) begin
                    check("rnd wr addr", 32'(st_addr[base+i]), 32'(mp));
                    check("rnd wr data", 32'(st_data[base+i]), 32'(tx_buf[i]));
                    model_mem[mp] = tx_buf[i];
                    mp = (mp + 1) % DEPTH;
                end
            end else begin
                read_txn((op == 1), pb, n, 1'b1);
                if (op == 1) mp = int'(pb) % DEPTH;
                for (int i = 0; i < n; i++) begin
                    check("rnd read data", 32'(rx_buf[i]), 32'(model_mem[mp]));
                    mp = (mp + 1) % DEPTH;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_responder.md
# i2c_slave_responder

Synthesizable I2C slave that answers the iicmb_m_wb controller on one bus (scl/sda). It holds a small byte-addressable register memory behind a one-byte pointer: writes set the pointer and store data, reads stream data out. Each stored byte is also reported on a local one-cycle strobe. It connects to the open-drain `triand` scl/sda nets beside the controller and serves as an RTL target for the I2CMB bench.

## Interface
- `SLAVE_ADDR`, 7'h22: 7-bit I2C address that is acknowledged.
- `MEM_ADDR_WIDTH`, 4: memory holds 2**MEM_ADDR_WIDTH bytes, range 1..8.
- `clk_i` in 1: system clock, at least 16x SCL frequency.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `scl_i` in 1: bus SCL, asynchronous.
- `sda_i` in 1: bus SDA, asynchronous.
- `scl_o` out 1: SCL open-drain drive. Constant 1; there is no clock stretching.
- `sda_o` out 1: SDA open-drain drive. 0 pulls the line low; 1 releases it.
- `busy_o` out 1: high from an addressed START until STOP or NACK.
- `wr_valid_o` out 1: one-cycle strobe for each data byte stored.
- `wr_addr_o` out MEM_ADDR_WIDTH: memory index of the stored byte.
- `wr_data_o` out 8: value of the stored byte.

## Operation
- **Input conditioning:** scl_i and sda_i pass through 2-flop synchronizers plus one history flop. Edges and START/STOP are decoded from the synchronized values.
- **START:** synchronized SDA falls while SCL is high. Accepted in any state; a repeated START is included.
  - Clears the bit counter.
  - Enters ADDR.
- **STOP:** SDA rises while SCL is high. Accepted in any state.
  - Goes to IDLE.
  - Sets sda_o=1 and busy_o=0.
- **Bit sampling:** data is sampled on the detected SCL rising edge, MSB first.
- **Bit driving:** sda_o changes only on the detected SCL falling edge.
- **States:**
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits. If byte[7:1]==SLAVE_ADDR, go to ADDR_ACK with busy_o=1 and latch R/W=byte[0]. Otherwise go to WAIT_STOP with SDA released (NACK).
  - ADDR_ACK: sda_o=0 for the 9th clock. On the following SCL fall: if R/W=0, release SDA and go to WR_PTR. If R/W=1, drive bit 7 of mem[ptr] and go to RD_BYTE.
  - WR_PTR: shifts in 8 bits, then ptr <= byte[MEM_ADDR_WIDTH-1:0]. ACK, then go to WR_DATA.
  - WR_DATA: shifts in 8 bits.
    - On the 8th rising edge, in the next cycle: mem[ptr] <= byte; wr_valid_o=1 with wr_addr_o=ptr and wr_data_o=byte; ptr <= ptr+1 modulo 2**MEM_ADDR_WIDTH.
    - Then WR_ACK (ACK driven), then WR_DATA again.
  - RD_BYTE: drives 8 bits of the byte loaded at entry. After the 8th SCL fall, release SDA, set ptr <= ptr+1 (wrapping), and go to RD_ACK.
  - RD_ACK: samples master ACK on the 9th rising edge.
    - ACK (0): on the next fall, drive bit 7 of mem[ptr] and go to RD_BYTE.
    - NACK (1): go to WAIT_STOP with busy_o=0.
  - WAIT_STOP: SDA released; ignores bits until START or STOP.
- **Pointer:** persists across transactions. A read without a preceding pointer write continues from the current ptr.
- **Reset values:**
  - sda_o=1, scl_o=1, busy_o=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0.
  - ptr=0, all memory bytes 0, state IDLE.
  - Reset mid-transfer releases SDA in the cycle after rst_i is sampled high.

## Timing
- **Detection latency:** START, STOP and SCL edges are detected 3 clk_i cycles after the pin change, with no jitter beyond 1 cycle.
- **SDA drive:** sda_o updates 1 cycle after the detected SCL fall. That is 4 cycles after the pin, well inside the SCL low phase at the required 16x ratio.
- **Write strobe:** wr_valid_o asserts exactly once per stored byte, 1 cycle after the detected 8th rising edge. It is never asserted for the pointer byte, the address byte, or a partial byte.
- **Partial bytes:** START or STOP in mid-byte discards the partial byte. Memory and ptr remain unchanged.
- **Simultaneous events:** START/STOP detection takes priority over an edge decoded in the same cycle.

## Test plan
- Write `0x44`, `0x05`, `0xA5`, `0x3C`, STOP:
  - ACK on all four bytes.
  - wr_valid_o pulses (5,A5) then (6,3C).
  - mem[5]=A5, mem[6]=3C; ptr=7 afterwards.
- Pointer set by a write of `0x44`, `0x05`, then repeated START, `0x45`; read 2 bytes with ACK then NACK, then STOP:
  - Returns A5, 3C.
  - sda_o released after the NACK; busy_o=0.
- Address `0x46` (slave 0x23), write:
  - NACK on the 9th clock; SDA never driven.
  - No wr_valid_o; busy_o stays 0.
- MEM_ADDR_WIDTH=4 wrap: pointer 0x0F, then data `0x11`, `0x22`:
  - Writes land in mem[15] and mem[0].
  - A pointer byte of 0xF3 selects index 3.
- STOP after 4 data bits of a write byte:
  - No strobe; memory is unchanged.
  - Returns to IDLE with sda_o=1.
- rst_i high for 1 cycle while the slave drives 0 in RD_BYTE:
  - sda_o=1 in the next cycle and ptr=0.
  - The next addressed read returns mem[0]=00.
